// File: rtl/ase_hssi_loopback_pkg.sv
// Shared types and constants for the HSSI loopback responder: egress state,
// counter width and the default-sized beat layout.
package ase_hssi_loopback_pkg;

    localparam int CNT_W       = 32;
    localparam int BEAT_DATA_W = 64;
    localparam int BEAT_KEEP_W = BEAT_DATA_W / 8;
    localparam int BEAT_USER_W = 1;

    typedef enum logic {
        IDLE,
        SEND
    } egress_state_t;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0] tdata;
        logic [BEAT_KEEP_W-1:0] tkeep;
        logic                   tlast;
        logic [BEAT_USER_W-1:0] tuser;
    } beat_t;

endpackage

// File: rtl/ase_hssi_loopback_responder_if.sv
// AXI-Stream TX (AFU to far end) and RX (far end to AFU) bundle of one HSSI channel.
interface ase_hssi_loopback_responder_if #(
    parameter int DATA_W = 64,
    parameter int USER_W = 1
);
    logic                  tx_tvalid;
    logic                  tx_tready;
    logic [DATA_W-1:0]     tx_tdata;
    logic [DATA_W/8-1:0]   tx_tkeep;
    logic                  tx_tlast;
    logic [USER_W-1:0]     tx_tuser;

    logic                  rx_tvalid;
    logic [DATA_W-1:0]     rx_tdata;
    logic [DATA_W/8-1:0]   rx_tkeep;
    logic                  rx_tlast;
    logic [USER_W-1:0]     rx_tuser;

    modport master (
        output tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, tx_tuser,
        input  tx_tready,
        input  rx_tvalid, rx_tdata, rx_tkeep, rx_tlast, rx_tuser
    );

    modport slave (
        input  tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, tx_tuser,
        output tx_tready,
        output rx_tvalid, rx_tdata, rx_tkeep, rx_tlast, rx_tuser
    );
endinterface

// File: rtl/ase_hssi_loopback_responder_fifo.sv
// Store-and-forward packet FIFO: speculative and committed write pointers with
// rollback, and a registered read port that returns zero when not reading.
module ase_hssi_pkt_fifo #(
    parameter int W     = 74,
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         commit,
    input  logic         rollback,
    output logic         full,
    input  logic         rd_en,
    output logic [W-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_spec;
    logic [PW-1:0] wr_com;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  mem [DEPTH];

    // Occupancy counts uncommitted beats too, so an oversize packet always hits full.
    assign full = (wr_spec - rd_ptr) == PW'(DEPTH);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_spec[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_spec <= '0;
            wr_com  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (rollback)   wr_spec <= wr_com;
            else if (wr_en) wr_spec <= wr_spec + PW'(1);
            if (commit)     wr_com  <= wr_spec + PW'(1);
            if (rd_en) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr  <= rd_ptr + PW'(1);
            end else begin
                rd_data <= '0;
            end
        end
    end
endmodule

// File: rtl/ase_hssi_loopback_responder.sv
// Far-end emulation of one HSSI channel: buffers whole TX packets, drops those
// that do not fit, and replays committed packets contiguously on RX.
module ase_hssi_loopback_responder
    import ase_hssi_loopback_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int USER_W = 1,
    parameter int DEPTH  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ase_hssi_loopback_responder_if.slave bus,
    input  logic                 pause,
    output logic [CNT_W-1:0]     pkt_fwd_cnt,
    output logic [CNT_W-1:0]     pkt_drop_cnt
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int BEAT_W = DATA_W + KEEP_W + 1 + USER_W;
    localparam int PTR_W  = $clog2(DEPTH) + 1;

    logic [BEAT_W-1:0] wr_beat;
    logic [BEAT_W-1:0] rd_beat;
    logic              fifo_full;
    logic              dropping;
    logic              drop_now;
    logic              wr_en;
    logic              commit;
    logic              rollback;
    logic              rd_en;
    logic              done;
    logic [PTR_W-1:0]  pkt_avail;
    egress_state_t     state;

    assign bus.tx_tready = rst_n;

    assign wr_beat  = {bus.tx_tdata, bus.tx_tkeep, bus.tx_tlast, bus.tx_tuser};
    assign drop_now = dropping | fifo_full;
    assign wr_en    = bus.tx_tvalid & ~drop_now;
    assign commit   = wr_en & bus.tx_tlast;
    assign rollback = bus.tx_tvalid & bus.tx_tlast & drop_now;

    assign {bus.rx_tdata, bus.rx_tkeep, bus.rx_tlast, bus.rx_tuser} = rd_beat;

    // Launch fetches the first beat from IDLE; in SEND keep fetching until tlast is on RX.
    assign done  = (state == SEND) && bus.rx_tlast;
    assign rd_en = ((state == IDLE) && (pkt_avail != '0) && !pause) ||
                   ((state == SEND) && !bus.rx_tlast);

    ase_hssi_pkt_fifo #(
        .W     (BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_beat),
        .commit   (commit),
        .rollback (rollback),
        .full     (fifo_full),
        .rd_en    (rd_en),
        .rd_data  (rd_beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropping      <= 1'b0;
            pkt_avail     <= '0;
            pkt_fwd_cnt   <= '0;
            pkt_drop_cnt  <= '0;
            state         <= IDLE;
            bus.rx_tvalid <= 1'b0;
        end else begin
            if (bus.tx_tvalid) dropping <= bus.tx_tlast ? 1'b0 : drop_now;
            pkt_avail     <= pkt_avail + PTR_W'(commit) - PTR_W'(done);
            if (rollback) pkt_drop_cnt <= pkt_drop_cnt + CNT_W'(1);
            if (done)     pkt_fwd_cnt  <= pkt_fwd_cnt + CNT_W'(1);
            bus.rx_tvalid <= rd_en;
            case (state)
                IDLE:    if (rd_en) state <= SEND;
                SEND:    if (done)  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ase_hssi_loopback_responder.sv
// Directed bench for the HSSI loopback responder with an 8-beat FIFO.
module tb_ase_hssi_loopback_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pause = 1'b0;
    logic [31:0] pkt_fwd_cnt;
    logic [31:0] pkt_drop_cnt;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    typedef struct {
        int          c;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } rxb_t;
    rxb_t rxq[$];

    ase_hssi_loopback_responder_if #(.DATA_W(64), .USER_W(1)) bus ();

    ase_hssi_loopback_responder #(.DATA_W(64), .USER_W(1), .DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .pause        (pause),
        .pkt_fwd_cnt  (pkt_fwd_cnt),
        .pkt_drop_cnt (pkt_drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk)
        if (bus.rx_tvalid === 1'b1)
            rxq.push_back('{cyc, bus.rx_tdata, bus.rx_tkeep, bus.rx_tlast, bus.rx_tuser[0]});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rx(input string tag, input int i, input int ec, input logic [63:0] ed, input logic el);
        if (i >= rxq.size()) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: beat %0d missing, observed %0d beats", tag, i, rxq.size());
        end else begin
            chk({tag, "_cyc"}, 64'(rxq[i].c), 64'(ec));
            chk({tag, "_data"}, rxq[i].d, ed);
            chk({tag, "_last"}, 64'(rxq[i].l), 64'(el));
            chk({tag, "_keep"}, 64'(rxq[i].k), 64'hFF);
            chk({tag, "_user"}, 64'(rxq[i].u), 64'(ed[0]));
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic l);
        bus.tx_tvalid = v;
        bus.tx_tdata  = d;
        bus.tx_tkeep  = v ? 8'hFF : 8'h00;
        bus.tx_tlast  = l;
        bus.tx_tuser  = d[0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 64'h0, 1'b0);
    endtask

    initial begin
        int n;
        int m;
        bus.tx_tvalid = 1'b0;
        bus.tx_tdata  = '0;
        bus.tx_tkeep  = '0;
        bus.tx_tlast  = 1'b0;
        bus.tx_tuser  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_tvalid", 64'(bus.rx_tvalid), 64'h0);
        chk("rst_rx_tdata", bus.rx_tdata, 64'h0);
        chk("rst_tx_tready", 64'(bus.tx_tready), 64'h0);
        chk("rst_fwd", 64'(pkt_fwd_cnt), 64'h0);
        chk("rst_drop", 64'(pkt_drop_cnt), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("tx_tready_up", 64'(bus.tx_tready), 64'h1);
        @(posedge clk);
        #1;

        // Single 3-beat packet: RX two cycles after tlast
        drive(1'b1, 64'h11, 1'b0);
        drive(1'b1, 64'h22, 1'b0);
        n = cyc;
        drive(1'b1, 64'h33, 1'b1);
        idle(7);
        chk("single_count", 64'(rxq.size()), 64'd3);
        chk_rx("single_b0", 0, n + 2, 64'h11, 1'b0);
        chk_rx("single_b1", 1, n + 3, 64'h22, 1'b0);
        chk_rx("single_b2", 2, n + 4, 64'h33, 1'b1);
        chk("single_fwd", 64'(pkt_fwd_cnt), 64'd1);

        // Back-to-back 1-beat packets: exactly one idle cycle between them
        rxq.delete();
        n = cyc;
        drive(1'b1, 64'hA1, 1'b1);
        drive(1'b1, 64'hA2, 1'b1);
        idle(8);
        chk("b2b_count", 64'(rxq.size()), 64'd2);
        chk_rx("b2b_p0", 0, n + 2, 64'hA1, 1'b1);
        chk_rx("b2b_p1", 1, n + 4, 64'hA2, 1'b1);
        chk("b2b_fwd", 64'(pkt_fwd_cnt), 64'd3);

        // Overflow: 6-beat packet fits, following 4-beat packet does not
        rxq.delete();
        pause = 1'b1;
        for (int i = 0; i < 6; i++) drive(1'b1, 64'h60 + 64'(i), i == 5);
        for (int i = 0; i < 4; i++) drive(1'b1, 64'h40 + 64'(i), i == 3);
        idle(4);
        chk("ovf_drop", 64'(pkt_drop_cnt), 64'd1);
        chk("ovf_paused_count", 64'(rxq.size()), 64'd0);
        pause = 1'b0;
        m = cyc;
        idle(12);
        chk("ovf_count", 64'(rxq.size()), 64'd6);
        for (int i = 0; i < 6; i++) chk_rx("ovf_beat", i, m + 1 + i, 64'h60 + 64'(i), i == 5);
        chk("ovf_fwd", 64'(pkt_fwd_cnt), 64'd4);

        // Oversize 9-beat packet with an idle egress
        rxq.delete();
        for (int i = 0; i < 9; i++) drive(1'b1, 64'h90 + 64'(i), i == 8);
        idle(8);
        chk("oversize_drop", 64'(pkt_drop_cnt), 64'd2);
        chk("oversize_count", 64'(rxq.size()), 64'd0);
        chk("oversize_fwd", 64'(pkt_fwd_cnt), 64'd4);

        // Pause rising mid-replay does not cut the packet, next one waits
        rxq.delete();
        for (int i = 0; i < 3; i++) drive(1'b1, 64'hB0 + 64'(i), 1'b0);
        n = cyc;
        drive(1'b1, 64'hB3, 1'b1);
        idle(2);
        pause = 1'b1;
        drive(1'b1, 64'hC1, 1'b1);
        idle(8);
        chk("pause_count", 64'(rxq.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk_rx("pause_beat", i, n + 2 + i, 64'hB0 + 64'(i), i == 3);
        chk("pause_fwd", 64'(pkt_fwd_cnt), 64'd5);
        pause = 1'b0;
        m = cyc;
        idle(5);
        chk("unpause_count", 64'(rxq.size()), 64'd5);
        chk_rx("unpause_beat", 4, m + 1, 64'hC1, 1'b1);
        chk("unpause_fwd", 64'(pkt_fwd_cnt), 64'd6);

        // Reset during an RX replay and a half-received TX packet
        rxq.delete();
        for (int i = 0; i < 3; i++) drive(1'b1, 64'hE0 + 64'(i), i == 2);
        drive(1'b1, 64'hD0, 1'b0);
        drive(1'b1, 64'hD1, 1'b0);
        chk("prereset_rx_active", 64'(bus.rx_tvalid), 64'h1);
        bus.tx_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_rx_tvalid", 64'(bus.rx_tvalid), 64'h0);
        chk("midrst_rx_tdata", bus.rx_tdata, 64'h0);
        chk("midrst_rx_tkeep", 64'(bus.rx_tkeep), 64'h0);
        chk("midrst_rx_tlast", 64'(bus.rx_tlast), 64'h0);
        chk("midrst_fwd", 64'(pkt_fwd_cnt), 64'h0);
        chk("midrst_drop", 64'(pkt_drop_cnt), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rxq.delete();
        n = cyc;
        drive(1'b1, 64'hF0, 1'b0);
        drive(1'b1, 64'hF1, 1'b1);
        idle(6);
        chk("postrst_count", 64'(rxq.size()), 64'd2);
        chk_rx("postrst_b0", 0, n + 3, 64'hF0, 1'b0);
        chk_rx("postrst_b1", 1, n + 4, 64'hF1, 1'b1);
        chk("postrst_fwd", 64'(pkt_fwd_cnt), 64'd1);
        chk("postrst_drop", 64'(pkt_drop_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed %0d vectors", vectors);
        $fatal(1, "timeout");
    end
endmodule
